motor_cmd_writer: RTL and testbench
===================================

Name: motor_cmd_writer

Overview:
- Parametrised, multi-channel successor to the single-motor PWM register sequencer.
- Acts as an Avalon-MM write master, programming N_CH PWM/motor-driver register banks (TOTAL_DUR, HIGH_DUR, CONTROL) from signed per-channel speed commands.
- Fully honours waitrequest and writes a channel only when its command changes or a periodic refresh is due.
- Sits between the balance controller's speed outputs and the PWM peripherals on the lightweight bus.

Parameters:
- N_CH, 2, number of motor channels.
- SPEED_W, 21, width of each signed speed command.
- PERIOD, 7000, PWM total duration in clk ticks; also the HIGH_DUR saturation limit.
- ADDR_W, 6, s_address width.
- CH_STRIDE, 4, address offset between channel banks (channel c, register r is at c*CH_STRIDE + r).
- REFRESH_CYC, 1000000, forced-rewrite interval in clk cycles; 0 disables refresh.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  N_CH  per-channel motor enable (go bit).
- speed  in  N_CH*SPEED_W  packed signed speeds; channel c occupies bits [c*SPEED_W +: SPEED_W].
- fast_decay  in  1  decay-mode bit, common to all channels.
- s_cs  out  1  Avalon chipselect.
- s_address  out  ADDR_W  Avalon word address.
- s_write  out  1  Avalon write strobe.
- s_writedata  out  32  Avalon write data.
- waitrequest  in  1  slave stall.
- init_done  out  1  high once TOTAL_DUR has been written for every channel.
- busy  out  1  high while a transfer is outstanding.

Behaviour:
- Reset: all outputs 0; state INIT; channel pointer 0; shadow copies invalid; refresh counter 0.
- Registers: TOTAL_DUR=0, HIGH_DUR=1, CONTROL=2, each relative to the channel base.
- Per-channel command computation:
  - mag = |speed|; the most-negative value yields 2^(SPEED_W-1).
  - high = min(mag, PERIOD), zero-extended to 32 bits.
  - fwd = (speed >= 0).
  - ctrl = {29'b0, fast_decay, fwd, run[c]}.
- Bus protocol:
  - s_cs and s_write assert together. s_address and s_writedata are stable while waitrequest=1.
  - A transfer completes on the cycle with s_write=1 and waitrequest=0.
  - s_cs and s_write drop for exactly one cycle after every completed transfer; no back-to-back strobes.
  - busy equals s_write.
- FSM states:
  - INIT: write TOTAL_DUR=PERIOD for channels 0..N_CH-1 in order, then set init_done (sticky until reset) and go to SCAN.
  - SCAN: one cycle per channel, round-robin. Snapshot high/ctrl for the current channel. If the shadow is invalid, the snapshot differs from the shadow, or the channel's refresh flag is set, go to WR_HIGH; otherwise advance the pointer (wrapping N_CH-1 to 0).
  - WR_HIGH: write the snapshot high to HIGH_DUR; on completion go to WR_CTRL.
  - WR_CTRL: write the snapshot ctrl to CONTROL. On completion, update the shadow, clear the refresh flag, advance the pointer, and return to SCAN.
  - On refresh, TOTAL_DUR is also rewritten before HIGH_DUR.
- Latency: a speed change is visible on the bus at most N_CH+1 cycles after it occurs, when there are no stalls and the bus is idle.
- Coherency: the snapshot is frozen for the whole HIGH_DUR/CONTROL pair; input changes mid-transaction are picked up on the next visit.
- Refresh: the counter counts to REFRESH_CYC-1, then sets the refresh flags of all channels and wraps. Flags already set stay set. The counter runs in every state.
- Indefinite waitrequest: the transfer is held forever; no timeout.
- Reset mid-transfer: s_write drops asynchronously; the block restarts in INIT.
- Arithmetic: compare mag against PERIOD at SPEED_W+1 bits. PERIOD must be >0 and fit in 32 bits.

Decomposition:
- Package motor_pkg:
  - register offset constants REG_TOTAL_DUR, REG_HIGH_DUR, REG_CONTROL;
  - control-word bit positions (GO=0, FWD=1, DECAY=2);
  - state enum typedef.
- One natural sub-module, motor_cmd_calc: purely combinational speed to {high, ctrl} conversion, instantiated once on the muxed current channel.

Test Plan (N_CH=2, PERIOD=7000, REFRESH_CYC=0 unless noted):
- Release reset, waitrequest=0 -> writes (addr 0, 7000), (addr 4, 7000), init_done=1, then HIGH/CTRL pairs for both channels.
- After init, speed0=3500, run=2'b01 -> writes (1, 3500) then (2, 0x3); no further writes while inputs are static.
- speed1=-9000, fast_decay=1, run=2'b11 -> (5, 7000) then (6, 0x5); most-negative speed -> high=7000.
- Hold waitrequest=1 for 5 cycles during a HIGH_DUR write -> address/data/strobe held stable; CONTROL issued only after the stall; one idle cycle between the two writes.
- Change speed0 from 100 to 200 during its WR_HIGH -> current pair carries 100; the next scan writes 200.
- REFRESH_CYC=50, static inputs -> every 50 cycles each channel rewrites TOTAL_DUR, HIGH_DUR and CONTROL. Assert reset_n mid-write -> s_write=0 immediately and the INIT sequence repeats.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the multi-channel motor command writer.
//   - Register offsets inside one channel's PWM/motor-driver bank.
//   - Bit positions inside the CONTROL word.
//   - Writer FSM state encoding.
package motor_pkg;

    // Register offsets relative to a channel base address
    localparam int unsigned REG_TOTAL_DUR = 0;
    localparam int unsigned REG_HIGH_DUR  = 1;
    localparam int unsigned REG_CONTROL   = 2;

    // CONTROL word bit positions
    localparam int unsigned CTRL_GO    = 0;
    localparam int unsigned CTRL_FWD   = 1;
    localparam int unsigned CTRL_DECAY = 2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SCAN,
        ST_WR_TOTAL,
        ST_WR_HIGH,
        ST_WR_CTRL
    } motor_state_t;

endpackage

// File: rtl/motor_cmd_calc.sv
// Combinational conversion of one signed speed command into the HIGH_DUR
// and CONTROL register values.
//   speed      : signed speed command
//   run_bit    : channel enable (go bit)
//   fast_decay : decay-mode bit
//   high       : min(|speed|, PERIOD), zero-extended to 32 bits
//   ctrl       : {29'b0, fast_decay, fwd, run_bit}
module motor_cmd_calc
    import motor_pkg::*;
#(
    parameter int SPEED_W = 21,
    parameter int PERIOD  = 7000
) (
    input  logic signed [SPEED_W-1:0] speed,
    input  logic                      run_bit,
    input  logic                      fast_decay,
    output logic [31:0]               high,
    output logic [31:0]               ctrl
);

    // Comparison width wide enough for both |speed| and any 32-bit PERIOD
    localparam int CMP_W = (SPEED_W + 1 > 33) ? SPEED_W + 1 : 33;

    logic signed [SPEED_W:0] speed_ext;
    logic        [SPEED_W:0] mag_n;
    logic        [CMP_W-1:0] mag;
    logic        [CMP_W-1:0] period_ext;

    always_comb begin
        // One extra bit so the most-negative input negates to 2^(SPEED_W-1)
        speed_ext  = {speed[SPEED_W-1], speed};
        mag_n      = speed[SPEED_W-1] ? -speed_ext : speed_ext;
        mag        = CMP_W'(mag_n);
        period_ext = CMP_W'(PERIOD);
        high       = (mag > period_ext) ? 32'(PERIOD) : 32'(mag);

        ctrl             = '0;
        ctrl[CTRL_GO]    = run_bit;
        ctrl[CTRL_FWD]   = ~speed[SPEED_W-1];
        ctrl[CTRL_DECAY] = fast_decay;
    end

endmodule

// File: rtl/motor_cmd_writer.sv
// Avalon-MM write master that programs N_CH PWM/motor-driver register banks
// from signed per-channel speed commands. After an initial TOTAL_DUR pass it
// scans channels round-robin and rewrites HIGH_DUR/CONTROL only when a
// channel's command changed or a periodic refresh is due (refresh also
// rewrites TOTAL_DUR).
//   clk, reset_n   : clock, asynchronous active-low reset
//   run            : per-channel go bits
//   speed          : packed signed speeds, channel c at [c*SPEED_W +: SPEED_W]
//   fast_decay     : decay-mode bit shared by all channels
//   s_cs, s_write  : Avalon chipselect / write strobe (always equal)
//   s_address      : word address, channel c register r at c*CH_STRIDE + r
//   s_writedata    : write data
//   waitrequest    : slave stall
//   init_done      : sticky, set once every channel's TOTAL_DUR was written
//   busy           : transfer outstanding (equals s_write)
module motor_cmd_writer
    import motor_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int SPEED_W     = 21,
    parameter int PERIOD      = 7000,
    parameter int ADDR_W      = 6,
    parameter int CH_STRIDE   = 4,
    parameter int REFRESH_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         run,
    input  logic [N_CH*SPEED_W-1:0] speed,
    input  logic                    fast_decay,
    output logic                    s_cs,
    output logic [ADDR_W-1:0]       s_address,
    output logic                    s_write,
    output logic [31:0]             s_writedata,
    input  logic                    waitrequest,
    output logic                    init_done,
    output logic                    busy
);

    localparam int              PTR_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N_CH - 1);
    localparam logic [31:0]     PERIOD_W = 32'(PERIOD);

    motor_state_t      state_reg;
    logic [PTR_W-1:0]  ch_ptr_reg;
    logic              s_write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       data_reg;
    logic              init_done_reg;
    logic [N_CH-1:0]   shadow_valid_reg;
    logic [N_CH-1:0]   refresh_flag_reg;
    logic [31:0]       shadow_high_reg [N_CH];
    logic [31:0]       shadow_ctrl_reg [N_CH];
    logic [31:0]       snap_high_reg;
    logic [31:0]       snap_ctrl_reg;

    logic signed [SPEED_W-1:0] speed_arr [N_CH];
    logic [ADDR_W-1:0]         base_arr  [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign speed_arr[gi] = speed[gi*SPEED_W +: SPEED_W];
            assign base_arr[gi]  = ADDR_W'(gi * CH_STRIDE);
        end
    endgenerate

    // Current-channel view, shared by the single calculator instance
    logic signed [SPEED_W-1:0] cur_speed;
    logic                      cur_run;
    logic [31:0]               calc_high;
    logic [31:0]               calc_ctrl;
    logic [ADDR_W-1:0]         addr_total;
    logic [ADDR_W-1:0]         addr_high;
    logic [ADDR_W-1:0]         addr_ctrl;
    logic [PTR_W-1:0]          next_ptr;
    logic                      need_write;

    always_comb begin
        cur_speed  = speed_arr[ch_ptr_reg];
        cur_run    = run[ch_ptr_reg];
        addr_total = base_arr[ch_ptr_reg] + ADDR_W'(REG_TOTAL_DUR);
        addr_high  = base_arr[ch_ptr_reg] + ADDR_W'(REG_HIGH_DUR);
        addr_ctrl  = base_arr[ch_ptr_reg] + ADDR_W'(REG_CONTROL);
        next_ptr   = (ch_ptr_reg == LAST_CH) ? '0 : ch_ptr_reg + 1'b1;
        need_write = !shadow_valid_reg[ch_ptr_reg]
                   || (calc_high != shadow_high_reg[ch_ptr_reg])
                   || (calc_ctrl != shadow_ctrl_reg[ch_ptr_reg])
                   || refresh_flag_reg[ch_ptr_reg];
    end

    motor_cmd_calc #(
        .SPEED_W (SPEED_W),
        .PERIOD  (PERIOD)
    ) u_calc (
        .speed      (cur_speed),
        .run_bit    (cur_run),
        .fast_decay (fast_decay),
        .high       (calc_high),
        .ctrl       (calc_ctrl)
    );

    // Free-running refresh timer; pulses refresh_tick on its last count
    logic refresh_tick;
    generate
        if (REFRESH_CYC > 0) begin : g_refresh
            localparam int CNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYC - 1);
            logic [CNT_W-1:0] refresh_cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    refresh_cnt_reg <= '0;
                end else if (refresh_cnt_reg == CNT_LAST) begin
                    refresh_cnt_reg <= '0;
                end else begin
                    refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
                end
            end

            assign refresh_tick = (refresh_cnt_reg == CNT_LAST);
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    // Each write state first raises the strobe (when it is low), then waits
    // for waitrequest=0. Completion always drops the strobe, so the next
    // state's issue cycle provides the mandatory idle cycle between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_INIT;
            ch_ptr_reg       <= '0;
            s_write_reg      <= 1'b0;
            addr_reg         <= '0;
            data_reg         <= '0;
            init_done_reg    <= 1'b0;
            shadow_valid_reg <= '0;
            refresh_flag_reg <= '0;
            snap_high_reg    <= '0;
            snap_ctrl_reg    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                shadow_high_reg[i] <= '0;
                shadow_ctrl_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (!s_write_reg) begin
                        s_write_reg <= 1'b1;
                        addr_reg    <= addr_total;
                        data_reg    <= PERIOD_W;
                    end else if (!waitrequest) begin
                        s_write_reg <= 1'b0;
                        ch_ptr_reg  <= next_ptr;
                        if (ch_ptr_reg == LAST_CH) begin
                            init_done_reg <= 1'b1;
                            state_reg     <= ST_SCAN;
                        end
                    end
                end

                ST_SCAN: begin
                    // Snapshot is frozen here for the whole register group
                    snap_high_reg <= calc_high;
                    snap_ctrl_reg <= calc_ctrl;
                    if (need_write) begin
                        s_write_reg <= 1'b1;
                        if (refresh_flag_reg[ch_ptr_reg]) begin
                            state_reg <= ST_WR_TOTAL;
                            addr_reg  <= addr_total;
                            data_reg  <= PERIOD_W;
                        end else begin
                            state_reg <= ST_WR_HIGH;
                            addr_reg  <= addr_high;
                            data_reg  <= calc_high;
                        end
                    end else begin
                        ch_ptr_reg <= next_ptr;
                    end
                end

                ST_WR_TOTAL: begin
                    if (!s_write_reg) begin
                        s_write_reg <= 1'b1;
                        addr_reg    <= addr_total;
                        data_reg    <= PERIOD_W;
                    end else if (!waitrequest) begin
                        s_write_reg <= 1'b0;
                        state_reg   <= ST_WR_HIGH;
                    end
                end

                ST_WR_HIGH: begin
                    if (!s_write_reg) begin
                        s_write_reg <= 1'b1;
                        addr_reg    <= addr_high;
                        data_reg    <= snap_high_reg;
                    end else if (!waitrequest) begin
                        s_write_reg <= 1'b0;
                        state_reg   <= ST_WR_CTRL;
                    end
                end

                ST_WR_CTRL: begin
                    if (!s_write_reg) begin
                        s_write_reg <= 1'b1;
                        addr_reg    <= addr_ctrl;
                        data_reg    <= snap_ctrl_reg;
                    end else if (!waitrequest) begin
                        s_write_reg                  <= 1'b0;
                        shadow_high_reg[ch_ptr_reg]  <= snap_high_reg;
                        shadow_ctrl_reg[ch_ptr_reg]  <= snap_ctrl_reg;
                        shadow_valid_reg[ch_ptr_reg] <= 1'b1;
                        refresh_flag_reg[ch_ptr_reg] <= 1'b0;
                        ch_ptr_reg                   <= next_ptr;
                        state_reg                    <= ST_SCAN;
                    end
                end

                default: begin
                    state_reg   <= ST_INIT;
                    s_write_reg <= 1'b0;
                end
            endcase

            // A new refresh request overrides a same-cycle flag clear
            if (refresh_tick) begin
                refresh_flag_reg <= '1;
            end
        end
    end

    assign s_cs        = s_write_reg;
    assign s_write     = s_write_reg;
    assign busy        = s_write_reg;
    assign s_address   = addr_reg;
    assign s_writedata = data_reg;
    assign init_done   = init_done_reg;

endmodule

// File: tb/tb_motor_cmd_writer.sv
// Directed bench for motor_cmd_writer: one instance without refresh for the
// command/stall/coherency/reset scenarios, one with REFRESH_CYC=50.
module tb_motor_cmd_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [1:0]  run;
    logic [41:0] speed;
    logic        fast_decay;
    logic        waitrequest;
    logic        s_cs, s_write, init_done, busy;
    logic [5:0]  s_address;
    logic [31:0] s_writedata;

    logic [1:0]  run_r;
    logic [41:0] speed_r;
    logic        fast_decay_r;
    logic        waitrequest_r;
    logic        s_cs_r, s_write_r, init_done_r, busy_r;
    logic [5:0]  s_address_r;
    logic [31:0] s_writedata_r;

    motor_cmd_writer #(
        .N_CH(2), .SPEED_W(21), .PERIOD(7000), .ADDR_W(6), .CH_STRIDE(4), .REFRESH_CYC(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .speed(speed), .fast_decay(fast_decay),
        .s_cs(s_cs), .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
        .waitrequest(waitrequest), .init_done(init_done), .busy(busy)
    );

    motor_cmd_writer #(
        .N_CH(2), .SPEED_W(21), .PERIOD(7000), .ADDR_W(6), .CH_STRIDE(4), .REFRESH_CYC(50)
    ) dut_r (
        .clk(clk), .reset_n(reset_n), .run(run_r), .speed(speed_r), .fast_decay(fast_decay_r),
        .s_cs(s_cs_r), .s_address(s_address_r), .s_write(s_write_r), .s_writedata(s_writedata_r),
        .waitrequest(waitrequest_r), .init_done(init_done_r), .busy(busy_r)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Bus monitors: completed writes plus protocol rule violations
    int q_addr[$];
    int q_data[$];
    int q_r_addr[$];
    int q_r_data[$];
    int q_r_stamp[$];
    int gap_err = 0, stab_err = 0, proto_err = 0;
    logic        prev_done = 1'b0, prev_stall = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (busy !== s_write || s_cs !== s_write) proto_err++;
            if (prev_done && s_write) gap_err++;
            if (prev_stall && (!s_write || s_address !== prev_addr || s_writedata !== prev_data))
                stab_err++;
            if (s_write && !waitrequest) begin
                q_addr.push_back(int'(s_address));
                q_data.push_back(int'(s_writedata));
            end
            prev_done  = s_write && !waitrequest;
            prev_stall = s_write && waitrequest;
            prev_addr  = s_address;
            prev_data  = s_writedata;
        end
        if (reset_n && s_write_r && !waitrequest_r) begin
            q_r_addr.push_back(int'(s_address_r));
            q_r_data.push_back(int'(s_writedata_r));
            q_r_stamp.push_back(cyc);
        end
    end

    task automatic set_speed(input int c, input int v);
        speed[c*21 +: 21] = 21'(v);
    endtask

    task automatic pop_raw(input string tag, output int a, output int d);
        int n = 0;
        while (q_addr.size() == 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (q_addr.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
            a = 63;
            d = -1;
        end else begin
            a = q_addr.pop_front();
            d = q_data.pop_front();
        end
    endtask

    task automatic pop_w(input string tag, input int ea, input int ed);
        int a, d;
        pop_raw(tag, a, d);
        chk({tag, "_addr"}, a, ea);
        chk({tag, "_data"}, d, ed);
    endtask

    // Order-independent HIGH/CTRL pairs, expected data looked up by address
    int exp_tab[64];
    task automatic pop_pairs(input string tag, input int n);
        int a1, d1, a2, d2;
        for (int i = 0; i < n; i++) begin
            pop_raw(tag, a1, d1);
            chk({tag, "_hi_off"}, a1 % 4, 1);
            chk({tag, "_hi_data"}, d1, exp_tab[a1]);
            pop_raw(tag, a2, d2);
            chk({tag, "_ctrl_addr"}, a2, a1 + 1);
            chk({tag, "_ctrl_data"}, d2, exp_tab[a2]);
        end
    endtask

    task automatic quiet(input string tag);
        repeat (20) @(posedge clk);
        #1;
        chk(tag, q_addr.size(), 0);
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        while (!s_write && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_strobe"}, s_write, 1);
    endtask

    int init_a[6] = '{0, 4, 1, 2, 5, 6};
    int init_d[6] = '{7000, 7000, 500, 2, 20, 1};
    int blk_a[6]  = '{0, 1, 2, 4, 5, 6};
    int blk_d[6]  = '{7000, 500, 2, 7000, 20, 1};

    initial begin
        int rel_cyc;
        reset_n       = 1'b0;
        run           = 2'b00;
        speed         = '0;
        fast_decay    = 1'b0;
        waitrequest   = 1'b0;
        run_r         = 2'b10;
        speed_r       = {21'(-20), 21'(500)};
        fast_decay_r  = 1'b0;
        waitrequest_r = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", s_write, 0);
        chk("rst_cs", s_cs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_addr", s_address, 0);
        chk("rst_data", s_writedata, 0);

        reset_n = 1'b1;
        rel_cyc = cyc;
        repeat (180) @(posedge clk);
        #1;

        // Refresh instance: init pass then one block per 50-cycle tick
        chk("ref_count", q_r_addr.size(), 24);
        if (q_r_addr.size() >= 24) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("ref_init%0d_addr", i), q_r_addr[i], init_a[i]);
                chk($sformatf("ref_init%0d_data", i), q_r_data[i], init_d[i]);
            end
            for (int b = 1; b < 4; b++) begin
                for (int i = 0; i < 6; i++) begin
                    chk($sformatf("ref_b%0d_%0d_addr", b, i), q_r_addr[b*6+i], blk_a[i]);
                    chk($sformatf("ref_b%0d_%0d_data", b, i), q_r_data[b*6+i], blk_d[i]);
                end
            end
            chk("ref_first_at", q_r_stamp[6] - rel_cyc, 51);
            chk("ref_period1", q_r_stamp[12] - q_r_stamp[6], 50);
            chk("ref_period2", q_r_stamp[18] - q_r_stamp[12], 50);
        end
        chk("ref_init_done", init_done_r, 1);

        // Main instance: init pass, then first HIGH/CTRL pairs, then silence
        chk("init_qsize", q_addr.size(), 6);
        pop_w("init_t0", 0, 7000);
        pop_w("init_t1", 4, 7000);
        pop_w("init_h0", 1, 0);
        pop_w("init_c0", 2, 2);
        pop_w("init_h1", 5, 0);
        pop_w("init_c1", 6, 2);
        chk("init_done", init_done, 1);

        set_speed(0, 3500);
        run = 2'b01;
        pop_w("sp3500_h", 1, 3500);
        pop_w("sp3500_c", 2, 3);
        quiet("sp3500_quiet");

        // Decay change touches both channels; order depends on scan phase
        set_speed(1, -50);
        fast_decay = 1'b1;
        run = 2'b11;
        exp_tab[1] = 3500; exp_tab[2] = 7;
        exp_tab[5] = 50;   exp_tab[6] = 5;
        pop_pairs("both", 2);
        quiet("both_quiet");

        set_speed(1, -(1 << 20));
        pop_w("mostneg_h", 5, 7000);
        pop_w("mostneg_c", 6, 5);
        set_speed(1, -9000);
        quiet("neg9000_quiet");

        set_speed(0, 7000);
        pop_w("p7000_h", 1, 7000);
        pop_w("p7000_c", 2, 7);
        set_speed(0, 7001);
        quiet("p7001_quiet");
        set_speed(0, -7000);
        pop_w("n7000_h", 1, 7000);
        pop_w("n7000_c", 2, 5);
        set_speed(0, -6999);
        pop_w("n6999_h", 1, 6999);
        pop_w("n6999_c", 2, 5);

        // Stall a HIGH_DUR write for 5 cycles
        waitrequest = 1'b1;
        set_speed(0, 1234);
        wait_write("stall");
        chk("stall_addr", s_address, 1);
        chk("stall_data", s_writedata, 1234);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d_w", i), s_write, 1);
            chk($sformatf("stall_hold%0d_a", i), s_address, 1);
            chk($sformatf("stall_hold%0d_d", i), s_writedata, 1234);
        end
        waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("stall_gap", s_write, 0);
        @(posedge clk); #1;
        chk("stall_ctrl_w", s_write, 1);
        chk("stall_ctrl_a", s_address, 2);
        chk("stall_ctrl_d", s_writedata, 7);
        pop_w("stall_h", 1, 1234);
        pop_w("stall_c", 2, 7);
        quiet("stall_quiet");

        // Input changes mid-pair land on the following visit
        waitrequest = 1'b1;
        set_speed(0, 100);
        wait_write("coh");
        chk("coh_data", s_writedata, 100);
        set_speed(0, 200);
        repeat (2) @(posedge clk);
        #1;
        waitrequest = 1'b0;
        pop_w("coh_h100", 1, 100);
        pop_w("coh_c100", 2, 7);
        pop_w("coh_h200", 1, 200);
        pop_w("coh_c200", 2, 7);
        quiet("coh_quiet");

        // Reset while a write is stalled
        waitrequest = 1'b1;
        set_speed(0, 300);
        wait_write("mid_rst");
        reset_n = 1'b0;
        #1;
        chk("mid_rst_write", s_write, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_init_done", init_done, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_qsize", q_addr.size(), 0);
        waitrequest = 1'b0;
        reset_n = 1'b1;
        pop_w("reinit_t0", 0, 7000);
        pop_w("reinit_t1", 4, 7000);
        pop_w("reinit_h0", 1, 300);
        pop_w("reinit_c0", 2, 7);
        pop_w("reinit_h1", 5, 7000);
        pop_w("reinit_c1", 6, 5);
        chk("reinit_done", init_done, 1);
        quiet("reinit_quiet");

        chk("gap_violations", gap_err, 0);
        chk("stall_violations", stab_err, 0);
        chk("strobe_violations", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
